// File: rtl/imem_fetch_pkg.sv
// Shared types and defaults for the LC3 instruction-fetch sequencer.
// Widths match the 16-bit LC3 address and instruction formats.
package imem_fetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] PC_RESET_DEF = 16'h3000;
  localparam int                MEM_LAT_DEF  = 1;
  localparam int                TIMEOUT_DEF  = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    EXEC
  } fetch_state_t;

endpackage

// File: rtl/imem_fetch_timer.sv
// Loadable down-counter with a zero flag; the caller gates dec so the count
// never wraps below zero.
module imem_fetch_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// LC3 instruction-fetch sequencer: one fetch per instruction, fixed-latency
// capture, valid/ready hand-off to decode, PC advance on retirement.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_DEF,
  parameter int                MEM_LAT  = MEM_LAT_DEF,
  parameter int                TIMEOUT  = TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_fetch,
  output logic [ADDR_W-1:0]  PC,
  output logic               instrmem_rd,
  input  logic [INSTR_W-1:0] instr_dout,
  input  logic               complete_instr,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [ADDR_W-1:0]  npc,
  output logic               timeout_err
);

  localparam int LAT_W = 3;
  localparam int TO_W  = 8;

  fetch_state_t state, state_next;

  logic             lat_load, lat_dec, lat_zero;
  logic [LAT_W-1:0] unused_lat_cnt;
  logic             to_load, to_dec, to_zero, to_expire;
  logic [TO_W-1:0]  to_cnt;
  logic             retire;

  assign retire    = (state == EXEC) && complete_instr;
  assign lat_load  = (state == REQ);
  assign lat_dec   = (state == WAIT) && !lat_zero;
  assign to_load   = (state == HOLD) && ir_ready;
  assign to_dec    = (state == EXEC) && !complete_instr && !to_zero;
  // Expiry is the decrement that lands on zero; a same-cycle retire wins.
  assign to_expire = (state == EXEC) && !complete_instr && (to_cnt == TO_W'(1));

  imem_fetch_timer #(.W(LAT_W)) u_lat_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (lat_load),
    .load_val (LAT_W'(MEM_LAT - 1)),
    .dec      (lat_dec),
    .count    (unused_lat_cnt),
    .zero     (lat_zero)
  );

  imem_fetch_timer #(.W(TO_W)) u_to_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (to_load),
    .load_val (TO_W'(TIMEOUT)),
    .dec      (to_dec),
    .count    (to_cnt),
    .zero     (to_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the default assignment first keeps every path driven, so no latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable_fetch) state_next = REQ;
      REQ:  state_next = WAIT;
      WAIT: if (lat_zero) state_next = HOLD;
      HOLD: if (ir_ready) state_next = EXEC;
      EXEC: begin
        if (complete_instr) begin
          state_next = enable_fetch ? REQ : IDLE;
        end else if (to_expire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign instrmem_rd = (state == REQ);
  assign ir_valid    = (state == HOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      PC          <= PC_RESET;
      npc         <= PC_RESET;
      ir          <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == WAIT) && lat_zero) begin
        ir  <= instr_dout;
        npc <= PC + ADDR_W'(1);
      end
      if (retire) begin
        PC <= br_taken ? br_target : PC + ADDR_W'(1);
      end
      if (to_expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: two instances (MEM_LAT=1/TIMEOUT=64 and
// MEM_LAT=3/TIMEOUT=4), each fed by a latency-accurate memory model.
module tb_imem_fetch_ctrl;

  localparam int LAT0 = 1;
  localparam int TO0  = 64;
  localparam int LAT1 = 3;
  localparam int TO1  = 4;

  logic        clock;
  logic        reset          [2];
  logic        enable_fetch   [2];
  logic [15:0] pc             [2];
  logic        instrmem_rd    [2];
  logic [15:0] instr_dout     [2];
  logic        complete_instr [2];
  logic        br_taken       [2];
  logic [15:0] br_target      [2];
  logic [15:0] ir             [2];
  logic        ir_valid       [2];
  logic        ir_ready       [2];
  logic [15:0] npc            [2];
  logic        timeout_err    [2];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] npc;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int          k;
    int          rdy;
    int          cmp;
    logic        br;
    logic [15:0] tgt;
    logic        glitch;
    logic        drop_en;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] npc;
    logic [15:0] nxt;
  } vec_t;
  vec_t vecs[11];

  imem_fetch_ctrl #(.PC_RESET(16'h3000), .MEM_LAT(LAT0), .TIMEOUT(TO0)) u_dut0 (
    .clock          (clock),
    .reset          (reset[0]),
    .enable_fetch   (enable_fetch[0]),
    .PC             (pc[0]),
    .instrmem_rd    (instrmem_rd[0]),
    .instr_dout     (instr_dout[0]),
    .complete_instr (complete_instr[0]),
    .br_taken       (br_taken[0]),
    .br_target      (br_target[0]),
    .ir             (ir[0]),
    .ir_valid       (ir_valid[0]),
    .ir_ready       (ir_ready[0]),
    .npc            (npc[0]),
    .timeout_err    (timeout_err[0])
  );

  imem_fetch_ctrl #(.PC_RESET(16'h3000), .MEM_LAT(LAT1), .TIMEOUT(TO1)) u_dut1 (
    .clock          (clock),
    .reset          (reset[1]),
    .enable_fetch   (enable_fetch[1]),
    .PC             (pc[1]),
    .instrmem_rd    (instrmem_rd[1]),
    .instr_dout     (instr_dout[1]),
    .complete_instr (complete_instr[1]),
    .br_taken       (br_taken[1]),
    .br_target      (br_target[1]),
    .ir             (ir[1]),
    .ir_valid       (ir_valid[1]),
    .ir_ready       (ir_ready[1]),
    .npc            (npc[1]),
    .timeout_err    (timeout_err[1])
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : a + 16'h1000;
  endfunction

  // Memory returns data only in the single cycle it is valid; 16'hDEAD otherwise.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int L = (g == 0) ? LAT0 : LAT1;
    logic [15:0] a_q [7];
    logic        v_q [7];
    initial for (int i = 0; i < 7; i++) v_q[i] = 1'b0;
    always @(posedge clock) begin
      a_q[0] <= pc[g];
      v_q[0] <= instrmem_rd[g];
      for (int i = 1; i < 7; i++) begin
        a_q[i] <= a_q[i-1];
        v_q[i] <= v_q[i-1];
      end
    end
    assign instr_dout[g] = v_q[L-1] ? mem_word(a_q[L-1]) : 16'hDEAD;
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input int k);
    check($sformatf("i%0d rst_pc", k), pc[k], 16'h3000);
    check($sformatf("i%0d rst_npc", k), npc[k], 16'h3000);
    check($sformatf("i%0d rst_ir", k), ir[k], 16'h0000);
    check($sformatf("i%0d rst_rd", k), instrmem_rd[k], 1'b0);
    check($sformatf("i%0d rst_valid", k), ir_valid[k], 1'b0);
    check($sformatf("i%0d rst_to_err", k), timeout_err[k], 1'b0);
  endtask

  task automatic run_txn(input vec_t v);
    int   k, n, lat, to;
    exp_t e;
    k   = v.k;
    lat = (k == 0) ? LAT0 : LAT1;
    to  = (k == 0) ? TO0 : TO1;
    enable_fetch[k] = 1'b1;
    n = 0;
    while (instrmem_rd[k] !== 1'b1 && n < 16) begin tick(); n++; end
    check($sformatf("i%0d rd_seen pc=%h", k, v.pc), instrmem_rd[k], 1'b1);
    if (instrmem_rd[k] !== 1'b1) return;
    check($sformatf("i%0d fetch_pc", k), pc[k], v.pc);
    e.ir  = v.ir;
    e.npc = v.npc;
    sb_q.push_back(e);
    tick();
    if (v.drop_en) enable_fetch[k] = 1'b0;
    check($sformatf("i%0d rd_one_cycle", k), instrmem_rd[k], 1'b0);
    n = 1;
    while (ir_valid[k] !== 1'b1 && n < 16) begin tick(); n++; end
    check($sformatf("i%0d valid_seen", k), ir_valid[k], 1'b1);
    if (ir_valid[k] !== 1'b1) return;
    check($sformatf("i%0d capture_latency", k), n, lat + 1);
    for (int i = 0; i < v.rdy; i++) begin
      if (v.glitch && i == 0) begin
        complete_instr[k] = 1'b1;
        br_taken[k]       = 1'b1;
        br_target[k]      = 16'hABCD;
      end
      tick();
      complete_instr[k] = 1'b0;
      br_taken[k]       = 1'b0;
      check($sformatf("i%0d hold_valid c%0d", k, i), ir_valid[k], 1'b1);
      check($sformatf("i%0d hold_ir c%0d", k, i), ir[k], v.ir);
      check($sformatf("i%0d hold_pc c%0d", k, i), pc[k], v.pc);
    end
    ir_ready[k] = 1'b1;
    e = sb_q.pop_front();
    check($sformatf("i%0d sb_ir", k), ir[k], e.ir);
    check($sformatf("i%0d sb_npc", k), npc[k], e.npc);
    tick();
    ir_ready[k] = 1'b0;
    check($sformatf("i%0d exec_valid_low", k), ir_valid[k], 1'b0);
    // Stray br_taken without complete_instr must not move PC.
    br_taken[k]  = 1'b1;
    br_target[k] = 16'h7777;
    if (v.cmp < 0) begin
      for (int i = 0; i < to; i++) begin
        check($sformatf("i%0d to_pending c%0d", k, i), timeout_err[k], 1'b0);
        tick();
      end
      br_taken[k] = 1'b0;
      check($sformatf("i%0d to_set", k), timeout_err[k], 1'b1);
      check($sformatf("i%0d to_idle_rd", k), instrmem_rd[k], 1'b0);
      check($sformatf("i%0d to_pc", k), pc[k], v.nxt);
    end else begin
      for (int i = 0; i < v.cmp; i++) tick();
      complete_instr[k] = 1'b1;
      br_taken[k]       = v.br;
      br_target[k]      = v.tgt;
      tick();
      complete_instr[k] = 1'b0;
      br_taken[k]       = 1'b0;
      check($sformatf("i%0d next_pc", k), pc[k], v.nxt);
    end
    if (v.drop_en) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("i%0d idle_no_rd c%0d", k, i), instrmem_rd[k], 1'b0);
        tick();
      end
      check($sformatf("i%0d idle_pc", k), pc[k], v.nxt);
    end
  endtask

  initial begin
    int n;
    //           k rdy cmp br  tgt      gl    drop  pc        ir        npc       nxt
    vecs[0]  = '{0, 0,  3, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h3000, 16'h1234, 16'h3001, 16'h3001};
    vecs[1]  = '{0, 2,  1, 1'b1, 16'h4000, 1'b1, 1'b0, 16'h3001, 16'h4001, 16'h3002, 16'h4000};
    vecs[2]  = '{0, 0,  0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h4000, 16'h5000, 16'h4001, 16'hFFFF};
    vecs[3]  = '{0, 1,  2, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 16'h0FFF, 16'h0000, 16'h0000};
    vecs[4]  = '{0, 0,  1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h1000, 16'h0001, 16'h0001};
    vecs[5]  = '{0, 0,  0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 16'h1001, 16'h0002, 16'h0002};
    vecs[6]  = '{1, 5,  3, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h3000, 16'h1234, 16'h3001, 16'h3001};
    vecs[7]  = '{1, 0,  0, 1'b1, 16'h4000, 1'b0, 1'b0, 16'h3001, 16'h4001, 16'h3002, 16'h4000};
    vecs[8]  = '{1, 0, -1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4000, 16'h5000, 16'h4001, 16'h4000};
    vecs[9]  = '{1, 0,  1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4000, 16'h5000, 16'h4001, 16'h4001};
    vecs[10] = '{1, 0,  0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h3000, 16'h1234, 16'h3001, 16'h3001};

    for (int k = 0; k < 2; k++) begin
      reset[k]          = 1'b1;
      enable_fetch[k]   = 1'b0;
      complete_instr[k] = 1'b0;
      br_taken[k]       = 1'b0;
      br_target[k]      = 16'h0000;
      ir_ready[k]       = 1'b0;
    end
    tick();
    tick();
    check_reset(0);
    check_reset(1);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Timeout is sticky across a successful re-fetch; reset mid-WAIT clears all.
    check("i1 to_sticky", timeout_err[1], 1'b1);
    n = 0;
    while (instrmem_rd[1] !== 1'b1 && n < 16) begin tick(); n++; end
    check("i1 rst_seq rd_seen", instrmem_rd[1], 1'b1);
    tick();
    tick();
    reset[1]        = 1'b1;
    enable_fetch[1] = 1'b0;
    tick();
    check_reset(1);
    reset[1] = 1'b0;
    tick();
    check("i1 post_rst_idle_rd", instrmem_rd[1], 1'b0);
    check("i1 post_rst_pc", pc[1], 16'h3000);

    run_txn(vecs[10]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
